iic_slave_regs: RTL
===================

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C target address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of CLK flops on the SCL/SDA input synchronizers (minimum 2).
REQ-003 Ports, name direction width meaning:
- CLK  input  1  system clock; CLK SHALL be at least 20x the SCL rate.
- RSTn  input  1  reset, asynchronous, active-low.
- SCL  input  1  I2C clock from the initiator; no clock stretching.
- SDA  inout  1  I2C data; open-drain: driven 0 or high-Z, never driven 1.
- Reg_Addr  output  8  current register pointer.
- Wr_Data  output  8  received data byte.
- Wr_En  output  1  one-CLK write strobe; Reg_Addr/Wr_Data valid this cycle.
- Rd_Data  input  8  register contents at Reg_Addr.
- Rd_En  output  1  one-CLK strobe; Rd_Data is sampled in this cycle.
- Busy  output  1  high from address match until STOP.

Function
REQ-004 SHALL synchronize SCL and SDA through SYNC_STAGES flops and derive the edge pulses scl_rise, scl_fall, start and stop from the synchronized values only.
REQ-005 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-006 SHALL use the FSM states IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-007 SHALL treat START (including a repeated START) in any state as a transition to DEV_ADDR, clearing the bit counter and keeping Reg_Addr.
REQ-008 SHALL treat STOP in any state as a transition to IDLE, releasing SDA and deasserting Busy on the next cycle.
REQ-009 SHALL shift SDA in on scl_rise, MSB first, with an 8-bit shift register and a 3-bit counter.
REQ-010 On the 8th bit in DEV_ADDR, SHALL go to DEV_ACK if the upper 7 bits equal DEV_ADDR, otherwise to WAIT_STOP with no ACK and no strobes.
REQ-011 SHALL drive SDA low from the scl_fall that ends bit 8 until the scl_fall that ends the 9th (ACK) clock; SDA SHALL be released at all other times except read data 0 bits.
REQ-012 After DEV_ACK, SHALL go to WORD_ADDR when R/W=0, or to RD_DATA when R/W=1.
REQ-013 In WORD_ACK, SHALL load Reg_Addr with the received byte.
REQ-014 In WR_DATA, SHALL pulse Wr_En once, with Wr_Data set to the received byte, one cycle after the 8th scl_rise, and SHALL ACK.
REQ-015 SHALL increment Reg_Addr at the end of WR_ACK, then return to WR_DATA.
REQ-016 On entry to RD_DATA (the scl_fall ending an ACK), SHALL pulse Rd_En and capture Rd_Data in that same cycle.
REQ-017 In RD_DATA, SHALL drive each bit MSB first, changing SDA only in the cycle after scl_fall.
REQ-018 In RD_ACK, SHALL release SDA and sample the initiator's bit on scl_rise.
REQ-019 On ACK (0) in RD_ACK, SHALL increment Reg_Addr and read the next byte.
REQ-020 On NACK (1) in RD_ACK, SHALL go to WAIT_STOP.
REQ-021 Reg_Addr arithmetic SHALL be 8-bit and wrap from 8'hFF to 8'h00.
REQ-022 Wr_En and Rd_En SHALL never assert in the same cycle, and never outside an address-matched transaction.
REQ-023 A STOP or START mid-byte SHALL discard the partial byte with no strobe.

Reset
REQ-024 While RSTn is low, SHALL hold: state IDLE, SDA high-Z, Reg_Addr=8'h00, Wr_Data=8'h00, Wr_En=0, Rd_En=0, Busy=0, synchronizers=1.
REQ-025 Assertion of RSTn mid-transfer SHALL release SDA immediately (asynchronously).
REQ-026 After RSTn deasserts, SHALL ignore bus activity until the first START.

Structure
REQ-027 The FSM state encoding and the default device address 7'h1A SHALL live in a shared package iic_pkg.
REQ-028 Synchronization and edge/START/STOP detection SHALL be one sub-module, iic_line_sync.

Verification
REQ-029 Write: S, 0x34, 0x05, 0xA5, P -> three ACKs; one Wr_En with Reg_Addr=0x05 and Wr_Data=0xA5; Reg_Addr=0x06 after.
REQ-030 Mismatch: S, 0xA0, 0x05, P -> SDA never low; no Wr_En/Rd_En; Busy stays 0.
REQ-031 Random read: S, 0x34, 0x10, Sr, 0x35, Rd_Data=0xC3, initiator NACK, P -> SDA bits 1,1,0,0,0,0,1,1; one Rd_En; Reg_Addr=0x10 before the NACK.
REQ-032 Wrap: S, 0x34, 0xFF, 0x11, 0x22, P -> writes 0x11@0xFF and 0x22@0x00; Reg_Addr=0x01.
REQ-033 Abort: STOP after 4 data bits -> no Wr_En, state IDLE; RSTn low during ACK drive -> SDA high-Z with no CLK edge.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared I2C target definitions: FSM state encoding and default address.
package iic_pkg;

    localparam logic [6:0] IIC_DEV_ADDR_DFLT = 7'h1A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_WORD_ADDR,
        ST_WORD_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } iic_state_e;

endpackage

// File: rtl/iic_line_sync.sv
// SCL/SDA synchronizers with edge, START and STOP pulse detection.
module iic_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // START/STOP need SCL high on both samples so an SCL edge never aliases
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target exposing an 8-bit register pointer with write/read strobes.
module iic_slave_regs
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = IIC_DEV_ADDR_DFLT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] Reg_Addr,
    output logic [7:0] Wr_Data,
    output logic       Wr_En,
    input  logic [7:0] Rd_Data,
    output logic       Rd_En,
    output logic       Busy
);

    iic_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_s, scl_rise, scl_fall, start, stop;
    logic [7:0] rx_byte;
    logic       last_bit;

    iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    // Gated with RSTn so the bus is released without waiting for a clock
    assign SDA      = (sda_oe_q && RSTn) ? 1'b0 : 1'bz;
    assign Reg_Addr = reg_addr_q;
    assign Wr_Data  = wr_data_q;
    assign Wr_En    = wr_en_q;
    assign Rd_En    = rd_en_q;
    assign Busy     = busy_q;
    assign rx_byte  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        if (stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_DEV_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = ST_DEV_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WORD_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) state_d = ST_WORD_ACK;
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d   = ST_WR_ACK;
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_byte;
                    end
                end
                // First fall starts the ACK drive, second fall ends it
                ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ST_WORD_ACK) reg_addr_d = shift_q;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_WR_ACK) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = ST_WR_DATA;
                        end else if (state_q == ST_WORD_ACK) begin
                            state_d = ST_WR_DATA;
                        end else if (shift_q[0]) begin
                            state_d = ST_RD_DATA;
                            rd_en_d = 1'b1;
                        end else begin
                            state_d = ST_WORD_ADDR;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (rd_en_q) begin
                        tx_d      = Rd_Data;
                        sda_oe_d  = ~Rd_Data[7];
                        bit_cnt_d = 3'd0;
                    end else if (scl_fall) begin
                        if (last_bit) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_oe_d  = ~tx_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                    end else if (scl_fall) begin
                        if (shift_q[0]) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = ST_RD_DATA;
                            rd_en_d    = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
